// File: rtl/sliced_serial_adder.sv
// rtl/sliced_serial_adder.sv - multi-cycle sliced add/subtract unit with registered carry chain
//
// Purpose: adds or subtracts two WIDTH-bit operands SLICE bits per clock,
// carrying between slices through a register. An operation takes N = WIDTH/SLICE
// compute cycles followed by a one-cycle done pulse.
//
// Ports:
//   clk        in   system clock, rising edge
//   rst_n      in   asynchronous active-low reset
//   start      in   begin an operation (accepted when not busy)
//   operand_a  in   [WIDTH] first operand, captured on accepted start
//   operand_b  in   [WIDTH] second operand, captured on accepted start
//   carry_in   in   carry into bit 0 in add mode, ignored when subtracting
//   subtract   in   0: a+b+carry_in, 1: a-b
//   busy       out  high while slices are being processed
//   done       out  one-cycle pulse when sum/carry_out/overflow update
//   sum        out  [WIDTH] result, held until the next result lands
//   carry_out  out  carry out of the MSB (1 = no borrow when subtracting)
//   overflow   out  two's-complement signed overflow

module sliced_serial_adder #(
    parameter int WIDTH = 16,
    parameter int SLICE = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] operand_a,
    input  logic [WIDTH-1:0] operand_b,
    input  logic             carry_in,
    input  logic             subtract,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             carry_out,
    output logic             overflow
);

    localparam int N     = WIDTH / SLICE;
    localparam int IDX_W = (N > 1) ? $clog2(N) : 1;

    if ((SLICE < 1) || ((WIDTH % SLICE) != 0)) begin : g_bad_slice
        $error("sliced_serial_adder: WIDTH must be a positive multiple of SLICE");
    end

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    state_t             r_state;
    logic [WIDTH-1:0]   r_a;
    logic [WIDTH-1:0]   r_b;       // already inverted when subtracting
    logic [WIDTH-1:0]   r_res;
    logic               r_carry;
    logic [IDX_W-1:0]   r_idx;

    logic [SLICE-1:0]   w_a_sl;
    logic [SLICE-1:0]   w_b_sl;
    logic [SLICE:0]     w_sl_full;
    logic [SLICE-1:0]   w_sl_sum;
    logic               w_sl_cout;
    logic               w_msb_cin;
    logic               w_last;
    logic [WIDTH-1:0]   w_res_next;

    always_comb begin
        w_a_sl     = r_a[r_idx*SLICE +: SLICE];
        w_b_sl     = r_b[r_idx*SLICE +: SLICE];
        w_sl_full  = {1'b0, w_a_sl} + {1'b0, w_b_sl} + {{SLICE{1'b0}}, r_carry};
        w_sl_sum   = w_sl_full[SLICE-1:0];
        w_sl_cout  = w_sl_full[SLICE];
        // Carry into the MSB recovered from the MSB sum bit: s = a ^ b ^ cin.
        w_msb_cin  = w_a_sl[SLICE-1] ^ w_b_sl[SLICE-1] ^ w_sl_sum[SLICE-1];
        w_last     = (r_idx == IDX_W'(N - 1));
        w_res_next = r_res;
        w_res_next[r_idx*SLICE +: SLICE] = w_sl_sum;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= S_IDLE;
            r_a       <= '0;
            r_b       <= '0;
            r_res     <= '0;
            r_carry   <= 1'b0;
            r_idx     <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            sum       <= '0;
            carry_out <= 1'b0;
            overflow  <= 1'b0;
        end else begin
            done <= 1'b0;
            case (r_state)
                S_IDLE, S_DONE: begin
                    // DONE accepts start exactly like IDLE for back-to-back ops.
                    if (start) begin
                        r_a     <= operand_a;
                        r_b     <= operand_b ^ {WIDTH{subtract}};
                        r_carry <= subtract ? 1'b1 : carry_in;
                        r_res   <= '0;
                        r_idx   <= '0;
                        busy    <= 1'b1;
                        r_state <= S_RUN;
                    end else begin
                        busy    <= 1'b0;
                        r_state <= S_IDLE;
                    end
                end
                S_RUN: begin
                    r_res   <= w_res_next;
                    r_carry <= w_sl_cout;
                    if (w_last) begin
                        sum       <= w_res_next;
                        carry_out <= w_sl_cout;
                        overflow  <= w_msb_cin ^ w_sl_cout;
                        done      <= 1'b1;
                        busy      <= 1'b0;
                        r_idx     <= '0;
                        r_state   <= S_DONE;
                    end else begin
                        r_idx <= r_idx + IDX_W'(1);
                    end
                end
                default: begin
                    busy    <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/sliced_serial_adder.md
Name: sliced_serial_adder

Overview:
- Multi-cycle, parametrised add/subtract unit. Processes a WIDTH-bit operand pair SLICE bits per clock through a registered carry chain.
- Trades latency for area relative to a flat ripple adder.
- Sits beside the ALU datapath. Adds add/subtract mode, signed overflow detection and a start/done handshake.

Parameters:
- WIDTH, 16, operand and result width in bits.
- SLICE, 4, bits processed per cycle. WIDTH mod SLICE must be 0, otherwise elaboration fails.
- Derived: N = WIDTH/SLICE, the number of compute cycles.

Ports:
- clk  input  1  single system clock; all state changes on its rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- start  input  1  request to begin an operation; sampled only when busy=0.
- operand_a  input  WIDTH  first operand; captured on an accepted start.
- operand_b  input  WIDTH  second operand; captured on an accepted start.
- carry_in  input  1  carry into bit 0 in add mode; ignored in subtract mode.
- subtract  input  1  0: a+b+carry_in; 1: a-b. Captured on an accepted start.
- busy  output  1  high while the operation is in progress (RUN state).
- done  output  1  one-cycle pulse when the result becomes valid.
- sum  output  WIDTH  result; held stable until the next result lands.
- carry_out  output  1  carry out of the MSB. In subtract mode 1 means no borrow.
- overflow  output  1  two's-complement signed overflow.

Behaviour:
- Reset (rst_n=0, asynchronous):
  - State goes to IDLE; busy=0, done=0, sum=0, carry_out=0, overflow=0.
  - Internal operand, carry and slice-index registers clear.
  - An operation in progress is discarded and no done is produced.
- States: IDLE, RUN, DONE.
  - IDLE: start=1 at a rising edge → capture a, b^{WIDTH{subtract}}, mode, and initial carry into the working registers. Initial carry = carry_in for add, 1 for subtract. slice_idx=0, go to RUN.
  - RUN: each edge adds slice slice_idx (bits [slice_idx*SLICE +: SLICE]) plus the registered carry. The slice sum goes to the internal result register and the new carry to the carry register; slice_idx increments.
  - Leaving RUN: on the edge processing slice N-1, copy the result into sum, the final carry into carry_out, and (carry into MSB) XOR (carry out of MSB) into overflow. Go to DONE.
  - DONE: done=1 for exactly this cycle, busy=0. start=1 here is accepted exactly as in IDLE (back-to-back operation). Otherwise go to IDLE.
- Latency: start accepted at edge E0; outputs update and done rises at edge EN; done falls at EN+1. Throughput is one operation per N+1 cycles with start held high.
- sum, carry_out and overflow change only at the final RUN edge, never mid-computation; they hold the previous result during RUN.
- start while busy=1 is ignored, with no queuing. Operand and mode inputs are don't-care except at an accepted start.
- Wrap-around: results are modulo 2^WIDTH; the excess appears only on carry_out and overflow.
- SLICE=WIDTH is legal: N=1, so done arrives one edge after start.
- SLICE=1 gives a pure bit-serial adder.

Test Plan:
1. WIDTH=16, SLICE=4; add 0x1234+0x4321, carry_in=0 → sum=0x5555, carry_out=0, overflow=0. done pulses exactly 4 edges after the start edge and lasts 1 cycle; busy high for 4 cycles.
2. Add overflow cases:
   - 0xFFFF+0x0001, carry_in=0 → 0x0000, carry_out=1, overflow=0.
   - 0x7FFF+0x0001 → 0x8000, carry_out=0, overflow=1.
   - 0x0000+0x0000, carry_in=1 → 0x0001.
3. Subtract cases (carry_in driven to 1 to prove it is ignored):
   - 0x0005-0x0007 → 0xFFFE, carry_out=0, overflow=0.
   - 0x8000-0x0001 → 0x7FFF, carry_out=1, overflow=1.
4. Handshake:
   - Hold start=1 throughout with operands changed during RUN → only start-edge operands are used.
   - Second op 0x0001+0x0001 accepted in the DONE cycle → sum=0x0002 with done 4 edges later.
   - sum stays at the first result during the second RUN.
5. Reset: assert rst_n=0 asynchronously mid-RUN (after 2 slices) → sum/carry_out/overflow/busy/done go to 0 immediately without a clock edge. After release, no done appears; a fresh op completes correctly.
6. Reparametrise:
   - WIDTH=8, SLICE=1: 0xAA+0x55, carry_in=1 → sum=0x00, carry_out=1, overflow=0, 8-cycle latency.
   - WIDTH=8, SLICE=8: same op completes in 1 cycle.
   - WIDTH=10, SLICE=4 → elaboration error.
